// File: rtl/intensity.sv
`default_nettype none
// ============================================================================
// Module   : intensity
// Purpose  : Converts a 3x3 window of RGB pixels into a registered 3x3 grid
//            of 8-bit luma values (77R + 150G + 29B) >> 8.
// Revision : 1.0 - initial release
// ============================================================================
module intensity (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [215:0] pixelData,
  input  logic         intensity_enable,
  input  logic         edgedetect_enable,
  output logic [71:0]  iGrid
);

  localparam int unsigned C_NUM_PIX = 9;
  localparam logic [15:0] C_COEF_R  = 16'd77;
  localparam logic [15:0] C_COEF_G  = 16'd150;
  localparam logic [15:0] C_COEF_B  = 16'd29;

  logic [71:0] w_int;
  logic [71:0] r_grid;

  // Coefficients sum to 256, so the weighted sum never exceeds 16 bits.
  generate
    for (genvar k = 0; k < C_NUM_PIX; k++) begin : g_pix
      logic [7:0]  w_r;
      logic [7:0]  w_g;
      logic [7:0]  w_b;
      logic [15:0] w_sum;

      assign w_r   = pixelData[215-24*k -: 8];
      assign w_g   = pixelData[207-24*k -: 8];
      assign w_b   = pixelData[199-24*k -: 8];
      assign w_sum = C_COEF_R * {8'd0, w_r}
                   + C_COEF_G * {8'd0, w_g}
                   + C_COEF_B * {8'd0, w_b};
      assign w_int[71-8*k -: 8] = 8'(w_sum >> 8);
    end
  endgenerate

  // The edge detector owns the grid while it is consuming it.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_grid <= '0;
    end else if (!edgedetect_enable && intensity_enable) begin
      r_grid <= w_int;
    end
  end

  assign iGrid = r_grid;

endmodule
`default_nettype wire

// File: tb/tb_intensity.sv
`default_nettype none
// ============================================================================
// Module   : tb_intensity
// Purpose  : Self-checking bench for intensity against a luma reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intensity;

  logic         tb_clk;
  logic         n_rst;
  logic [215:0] pixel_data;
  logic         intensity_enable;
  logic         edgedetect_enable;
  logic [71:0]  igrid;

  int checks;
  int failures;
  logic [71:0] exp_grid;

  intensity dut (
    .clk               (tb_clk),
    .n_rst             (n_rst),
    .pixelData         (pixel_data),
    .intensity_enable  (intensity_enable),
    .edgedetect_enable (edgedetect_enable),
    .iGrid             (igrid)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  function automatic logic [71:0] ref_grid(input logic [215:0] pd);
    logic [71:0] g;
    g = '0;
    for (int k = 0; k < 9; k++) begin
      int r, gr, b, s;
      r  = int'(pd[215-24*k -: 8]);
      gr = int'(pd[207-24*k -: 8]);
      b  = int'(pd[199-24*k -: 8]);
      s  = 77*r + 150*gr + 29*b;
      g[71-8*k -: 8] = 8'(s / 256);
    end
    return g;
  endfunction

  function automatic logic [215:0] rand_window();
    logic [215:0] pd;
    for (int i = 0; i < 27; i++) pd[i*8 +: 8] = 8'($urandom);
    return pd;
  endfunction

  function automatic logic [215:0] set_pix(input logic [215:0] pd, input int k,
                                           input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    logic [215:0] o;
    o = pd;
    o[215-24*k -: 8] = r;
    o[207-24*k -: 8] = g;
    o[199-24*k -: 8] = b;
    return o;
  endfunction

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge tb_clk);
    n_rst = 1'b1;
    pixel_data = rand_window();
    intensity_enable = 1'b1;
    edgedetect_enable = 1'b1;
    tick();
    checks++;
    if (igrid !== 72'd0) begin
      failures++;
      $display("FAIL reset_initial: iGrid=%h expected=%h", igrid, 72'd0);
    end
    // load something, then reset mid-operation with enables high
    @(negedge tb_clk);
    n_rst = 1'b0;
    edgedetect_enable = 1'b0;
    pixel_data = rand_window();
    exp_grid = ref_grid(pixel_data);
    tick();
    checks++;
    if (igrid !== exp_grid) begin
      failures++;
      $display("FAIL reset_preload: iGrid=%h expected=%h", igrid, exp_grid);
    end
    @(negedge tb_clk);
    n_rst = 1'b1;
    pixel_data = rand_window();
    tick();
    exp_grid = '0;
    checks++;
    if (igrid !== exp_grid) begin
      failures++;
      $display("FAIL reset_midop: iGrid=%h expected=%h", igrid, exp_grid);
    end
    @(negedge tb_clk);
    n_rst = 1'b0;
    intensity_enable = 1'b0;
  endtask

  task automatic test_grey();
    int vals[9] = '{20, 20, 40, 60, 80, 100, 120, 144, 160};
    logic [215:0] pd;
    pd = '0;
    for (int k = 0; k < 9; k++) pd = set_pix(pd, k, 8'(vals[k]), 8'(vals[k]), 8'(vals[k]));
    @(negedge tb_clk);
    pixel_data = pd;
    intensity_enable = 1'b1;
    edgedetect_enable = 1'b0;
    tick();
    exp_grid = {8'd20, 8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd120, 8'd144, 8'd160};
    checks++;
    if (igrid !== exp_grid) begin
      failures++;
      $display("FAIL grey: iGrid=%h expected=%h", igrid, exp_grid);
    end
    @(negedge tb_clk);
    intensity_enable = 1'b0;
  endtask

  task automatic test_primaries();
    logic [215:0] pd;
    pd = '0;
    pd = set_pix(pd, 0, 8'd255, 8'd0,   8'd0);
    pd = set_pix(pd, 1, 8'd0,   8'd255, 8'd0);
    pd = set_pix(pd, 2, 8'd0,   8'd0,   8'd255);
    pd = set_pix(pd, 3, 8'd255, 8'd255, 8'd255);
    pd = set_pix(pd, 4, 8'd20,  8'd20,  8'd40);
    @(negedge tb_clk);
    pixel_data = pd;
    intensity_enable = 1'b1;
    tick();
    exp_grid = {8'd76, 8'd149, 8'd28, 8'd255, 8'd22, 8'd0, 8'd0, 8'd0, 8'd0};
    checks++;
    if (igrid !== exp_grid) begin
      failures++;
      $display("FAIL primaries: iGrid=%h expected=%h", igrid, exp_grid);
    end
    @(negedge tb_clk);
    intensity_enable = 1'b0;
  endtask

  task automatic test_hold_no_enable();
    @(negedge tb_clk);
    pixel_data = rand_window();
    intensity_enable = 1'b1;
    exp_grid = ref_grid(pixel_data);
    tick();
    checks++;
    if (igrid !== exp_grid) begin
      failures++;
      $display("FAIL hold_load: iGrid=%h expected=%h", igrid, exp_grid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge tb_clk);
      intensity_enable = 1'b0;
      pixel_data = rand_window();
      tick();
      checks++;
      if (igrid !== exp_grid) begin
        failures++;
        $display("FAIL hold_idle[%0d]: iGrid=%h expected=%h", c, igrid, exp_grid);
      end
    end
    @(negedge tb_clk);
    intensity_enable = 1'b1;
    exp_grid = ref_grid(pixel_data);
    tick();
    checks++;
    if (igrid !== exp_grid) begin
      failures++;
      $display("FAIL hold_reload: iGrid=%h expected=%h", igrid, exp_grid);
    end
    @(negedge tb_clk);
    intensity_enable = 1'b0;
  endtask

  task automatic test_edgedetect_freeze();
    for (int c = 0; c < 2; c++) begin
      @(negedge tb_clk);
      intensity_enable = 1'b1;
      edgedetect_enable = 1'b1;
      pixel_data = rand_window();
      tick();
      checks++;
      if (igrid !== exp_grid) begin
        failures++;
        $display("FAIL freeze[%0d]: iGrid=%h expected=%h", c, igrid, exp_grid);
      end
    end
    @(negedge tb_clk);
    edgedetect_enable = 1'b0;
    exp_grid = ref_grid(pixel_data);
    tick();
    checks++;
    if (igrid !== exp_grid) begin
      failures++;
      $display("FAIL freeze_release: iGrid=%h expected=%h", igrid, exp_grid);
    end
    @(negedge tb_clk);
    intensity_enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [215:0] win_a, win_b;
    logic [71:0]  exp_b;
    win_a = rand_window();
    win_b = rand_window();
    exp_b = ref_grid(win_b);
    @(negedge tb_clk);
    intensity_enable = 1'b1;
    edgedetect_enable = 1'b0;
    pixel_data = win_a;
    exp_grid = ref_grid(win_a);
    tick();
    checks++;
    if (igrid !== exp_grid) begin
      failures++;
      $display("FAIL b2b_a: iGrid=%h expected=%h", igrid, exp_grid);
    end
    @(negedge tb_clk);
    pixel_data = win_b;
    tick();
    checks++;
    if (igrid !== exp_b) begin
      failures++;
      $display("FAIL b2b_b: iGrid=%h expected=%h", igrid, exp_b);
    end
    exp_grid = exp_b;
    for (int n = 0; n < 1000; n++) begin
      @(negedge tb_clk);
      pixel_data = rand_window();
      exp_grid = ref_grid(pixel_data);
      tick();
      checks++;
      if (igrid !== exp_grid) begin
        failures++;
        $display("FAIL b2b_random[%0d]: iGrid=%h expected=%h", n, igrid, exp_grid);
      end
    end
    @(negedge tb_clk);
    intensity_enable = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_grid = '0;
    n_rst = 1'b1;
    pixel_data = '0;
    intensity_enable = 1'b0;
    edgedetect_enable = 1'b0;
    test_reset();
    test_grey();
    test_primaries();
    test_hold_no_enable();
    test_edgedetect_freeze();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
